// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IF-stage program-counter generator with trap/branch redirect, run/halt FSM and fetch counter
module pc_gen #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  START_ADDR = 32'h8000_0000,
    parameter logic [ADDR_W-1:0]  ALT_ADDR   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]  INST_END   = 32'h8000_3FFC,
    parameter int                 STEP       = 4,
    parameter int                 CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_mode,
    input  logic              fetch_en,
    input  logic              stall_i,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic              if_gnt_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              if_req_o,
    output logic              redirect_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  fetch_cnt_o
);

    localparam int LSB = (STEP == 2) ? 1 : 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  cnt_q;
    logic              redir;
    logic              target_misal;
    logic              accept;
    logic              redirect_q;
    logic              misalign_q;

    assign if_req_o = (state_q == RUN);
    assign accept   = if_req_o & if_gnt_i & ~stall_i;
    assign redir    = trap_flag_i | branch_flag_i;

    // Trap outranks branch; the losing branch target is simply dropped.
    assign target       = trap_flag_i ? trap_addr_i : branch_addr_i;
    assign target_misal = |target[LSB-1:0];

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            BOOT:    state_nxt = fetch_en ? RUN : HALT;
            RUN:     state_nxt = fetch_en ? RUN : HALT;
            HALT:    state_nxt = fetch_en ? RUN : HALT;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        pc_nxt = pc_q;
        if (redir) begin
            pc_nxt = {target[ADDR_W-1:LSB], {LSB{1'b0}}};
        end else if (accept) begin
            pc_nxt = (pc_q >= INST_END) ? START_ADDR : pc_q + ADDR_W'(STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= set_mode ? START_ADDR : ALT_ADDR;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            pc_q       <= pc_nxt;
            redirect_q <= redir;
            misalign_q <= redir & target_misal;
            // A granted fetch is counted even when a redirect overrides the next PC.
            if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_o        = pc_q;
    assign redirect_o  = redirect_q;
    assign misalign_o  = misalign_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        set_mode;
    logic        fetch_en;
    logic        stall_i;
    logic        trap_flag_i;
    logic [31:0] trap_addr_i;
    logic        branch_flag_i;
    logic [31:0] branch_addr_i;
    logic        if_gnt_i;
    logic [31:0] pc_o;
    logic        if_req_o;
    logic        redirect_o;
    logic        misalign_o;
    logic [15:0] fetch_cnt_o;

    int errors = 0;
    int checks = 0;

    pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .set_mode      (set_mode),
        .fetch_en      (fetch_en),
        .stall_i       (stall_i),
        .trap_flag_i   (trap_flag_i),
        .trap_addr_i   (trap_addr_i),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .if_gnt_i      (if_gnt_i),
        .pc_o          (pc_o),
        .if_req_o      (if_req_o),
        .redirect_o    (redirect_o),
        .misalign_o    (misalign_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          exp_cnt;
        int          n;

        rst = 1'b0; set_mode = 1'b1; fetch_en = 1'b1; stall_i = 1'b0;
        trap_flag_i = 1'b0; trap_addr_i = '0; branch_flag_i = 1'b0; branch_addr_i = '0;
        if_gnt_i = 1'b1;
        tick(); tick();
        chk("rst_pc", pc_o, 32'h8000_0000);
        chk("rst_req", {31'd0, if_req_o}, 32'd0);
        chk("rst_cnt", {16'd0, fetch_cnt_o}, 32'd0);
        chk("rst_redir", {31'd0, redirect_o}, 32'd0);
        chk("rst_misal", {31'd0, misalign_o}, 32'd0);

        // BOOT cycle, then sequential stepping with gnt held high
        rst = 1'b1;
        #1;
        chk("boot_req", {31'd0, if_req_o}, 32'd0);
        tick();
        chk("run_req", {31'd0, if_req_o}, 32'd1);
        chk("run_pc0", pc_o, 32'h8000_0000);
        tick();
        chk("seq_pc1", pc_o, 32'h8000_0004);
        chk("seq_cnt1", {16'd0, fetch_cnt_o}, 32'd1);
        tick();
        chk("seq_pc2", pc_o, 32'h8000_0008);
        chk("seq_cnt2", {16'd0, fetch_cnt_o}, 32'd2);
        tick();
        chk("seq_pc3", pc_o, 32'h8000_000C);
        chk("seq_cnt3", {16'd0, fetch_cnt_o}, 32'd3);

        // Waiting request: no grant for 3 cycles
        if_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_pc", pc_o, 32'h8000_000C);
            chk("wait_cnt", {16'd0, fetch_cnt_o}, 32'd3);
        end
        if_gnt_i = 1'b1;
        tick();
        chk("gnt_pc", pc_o, 32'h8000_0010);
        chk("gnt_cnt", {16'd0, fetch_cnt_o}, 32'd4);

        // Stall blocks advance and count even with grant
        stall_i = 1'b1;
        tick(); tick();
        chk("stall_pc", pc_o, 32'h8000_0010);
        chk("stall_cnt", {16'd0, fetch_cnt_o}, 32'd4);
        stall_i = 1'b0; if_gnt_i = 1'b0;

        // Jump to window end, then wrap on accept
        branch_flag_i = 1'b1; branch_addr_i = 32'h8000_3FFC;
        tick();
        chk("end_pc", pc_o, 32'h8000_3FFC);
        chk("end_redir", {31'd0, redirect_o}, 32'd1);
        chk("end_misal", {31'd0, misalign_o}, 32'd0);
        branch_flag_i = 1'b0; if_gnt_i = 1'b1;
        tick();
        chk("wrap_pc", pc_o, 32'h8000_0000);
        chk("wrap_cnt", {16'd0, fetch_cnt_o}, 32'd5);
        chk("wrap_redir", {31'd0, redirect_o}, 32'd0);

        // Trap and branch together with an accept: trap wins, fetch still counted
        trap_flag_i = 1'b1; trap_addr_i = 32'h0000_0100;
        branch_flag_i = 1'b1; branch_addr_i = 32'h8000_0200;
        tick();
        chk("prio_pc", pc_o, 32'h0000_0100);
        chk("prio_redir", {31'd0, redirect_o}, 32'd1);
        chk("prio_misal", {31'd0, misalign_o}, 32'd0);
        chk("prio_cnt", {16'd0, fetch_cnt_o}, 32'd6);
        trap_flag_i = 1'b0; branch_flag_i = 1'b0; if_gnt_i = 1'b0;
        tick();
        chk("prio_pulse_end", {31'd0, redirect_o}, 32'd0);
        chk("prio_hold", pc_o, 32'h0000_0100);

        // Misaligned branch target
        branch_flag_i = 1'b1; branch_addr_i = 32'h8000_0206;
        tick();
        chk("mis_pc", pc_o, 32'h8000_0204);
        chk("mis_flag", {31'd0, misalign_o}, 32'd1);
        branch_flag_i = 1'b0;
        tick();
        chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
        chk("mis_redir_end", {31'd0, redirect_o}, 32'd0);

        // Branch while halted
        fetch_en = 1'b0;
        tick();
        chk("halt_req", {31'd0, if_req_o}, 32'd0);
        branch_flag_i = 1'b1; branch_addr_i = 32'h8000_1000;
        tick();
        chk("halt_br_pc", pc_o, 32'h8000_1000);
        chk("halt_br_req", {31'd0, if_req_o}, 32'd0);
        chk("halt_br_redir", {31'd0, redirect_o}, 32'd1);
        branch_flag_i = 1'b0; fetch_en = 1'b1;
        tick();
        chk("resume_req", {31'd0, if_req_o}, 32'd1);
        chk("resume_pc", pc_o, 32'h8000_1000);

        // Counter wrap: run up to FFFF, then one more accept
        exp_cnt = 6;
        exp_pc  = 32'h8000_1000;
        if_gnt_i = 1'b1;
        n = 16'hFFFF - exp_cnt;
        for (int i = 0; i < n; i++) begin
            tick();
            exp_pc = (exp_pc >= 32'h8000_3FFC) ? 32'h8000_0000 : exp_pc + 32'd4;
        end
        chk("cnt_ffff", {16'd0, fetch_cnt_o}, 32'h0000_FFFF);
        chk("cnt_loop_pc", pc_o, exp_pc);
        tick();
        chk("cnt_wrap", {16'd0, fetch_cnt_o}, 32'd0);

        // Asynchronous reset mid-stall with a redirect pulse live
        stall_i = 1'b1; set_mode = 1'b0;
        branch_flag_i = 1'b1; branch_addr_i = 32'h8000_0100;
        tick();
        chk("pre_rst_redir", {31'd0, redirect_o}, 32'd1);
        branch_flag_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pc", pc_o, 32'h0000_0000);
        chk("arst_req", {31'd0, if_req_o}, 32'd0);
        chk("arst_redir", {31'd0, redirect_o}, 32'd0);
        chk("arst_cnt", {16'd0, fetch_cnt_o}, 32'd0);
        tick();
        rst = 1'b1; stall_i = 1'b0;
        tick();
        chk("alt_run_pc", pc_o, 32'h0000_0000);
        chk("alt_run_req", {31'd0, if_req_o}, 32'd1);
        tick();
        chk("alt_step_pc", pc_o, 32'h0000_0004);
        chk("alt_step_cnt", {16'd0, fetch_cnt_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter unit at the front of the IF stage.
- Produces the fetch address and drives a req/gnt handshake to the instruction-memory port.
- Applies redirects with fixed priority: trap first, then branch. Wraps at a configurable end of the instruction window.
- Provides a run/halt FSM, target alignment checking and an accepted-fetch counter.

Parameters:
- ADDR_W, 32, address and PC width in bits.
- START_ADDR, 32'h8000_0000, reset PC when set_mode=1; also the wrap target.
- ALT_ADDR, 32'h0000_0000, reset PC when set_mode=0.
- INST_END, 32'h8000_3FFC, last valid sequential fetch address. Must be STEP-aligned.
- STEP, 4, sequential increment in bytes. Legal values 2 and 4.
- CNT_W, 16, width of the accepted-fetch counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- set_mode  in  1  selects the reset PC: 1 gives START_ADDR, 0 gives ALT_ADDR. Sampled only while rst=0.
- fetch_en  in  1  enables sequential fetching. 0 requests HALT.
- stall_i  in  1  pipeline stall; blocks sequential advance.
- trap_flag_i  in  1  trap/exception redirect request.
- trap_addr_i  in  ADDR_W  trap handler address.
- branch_flag_i  in  1  branch/jump redirect request.
- branch_addr_i  in  ADDR_W  branch target.
- if_gnt_i  in  1  memory port accepts the current request.
- pc_o  out  ADDR_W  current fetch address.
- if_req_o  out  1  fetch request valid.
- redirect_o  out  1  one-cycle pulse: pc_o was loaded from a redirect this cycle.
- misalign_o  out  1  one-cycle pulse: the accepted redirect target was not STEP-aligned.
- fetch_cnt_o  out  CNT_W  count of accepted fetches.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_o = set_mode ? START_ADDR : ALT_ADDR.
  - State = BOOT.
  - if_req_o, redirect_o, misalign_o = 0; fetch_cnt_o = 0.
  - Reset asserted mid-operation discards any in-flight request; no handshake state survives reset.
- FSM states BOOT, RUN, HALT. if_req_o = (state==RUN), combinational from state.
  - BOOT: exactly one cycle after reset release, with no request. Then RUN if fetch_en=1, else HALT.
  - RUN: go to HALT when fetch_en=0 at a clock edge. The current request is dropped and pc_o holds.
  - HALT: go to RUN when fetch_en=1. pc_o holds.
- Accept condition: accept = if_req_o & if_gnt_i & ~stall_i.
- PC update priority at each rising edge (first match wins):
  1. trap_flag_i=1: pc_o <= trap_addr_i with bits[log2(STEP)-1:0] forced to 0.
  2. branch_flag_i=1: pc_o <= branch_addr_i with the same alignment masking.
  3. accept=1: pc_o <= (pc_o >= INST_END) ? START_ADDR : pc_o + STEP. The sum is taken modulo 2^ADDR_W.
  4. Otherwise pc_o holds.
- Redirects are honoured in every state, including BOOT and HALT, and regardless of stall_i and if_gnt_i. A redirect does not change the FSM state.
- Simultaneous trap and branch: the trap wins and the branch is discarded; no memory of the branch is kept.
- Simultaneous redirect and accept:
  - The redirect wins the PC update.
  - The accepted fetch is still counted, because that address was granted.
- redirect_o = 1 in the cycle after any redirect edge (registered), else 0.
- misalign_o = 1 in that same cycle only if the winning target had nonzero low bits.
- fetch_cnt_o increments by 1 on every accept and wraps modulo 2^CNT_W.
- pc_o changes only at clock edges and never while if_req_o=1 & if_gnt_i=0 without a redirect. This keeps the address stable while a request waits.

Test Plan:
- Reset with set_mode=1, fetch_en=1, if_gnt_i=1 held → pc_o=8000_0000, if_req_o=0 for 1 cycle, then pc_o steps 8000_0004, 8000_0008, …; fetch_cnt_o counts 1, 2, 3.
- pc_o=8000_3FFC, accept → next pc_o=8000_0000. Separately, reset with set_mode=0 → pc_o=0000_0000.
- RUN with if_gnt_i=0 for 3 cycles, then 1 → pc_o stable for 3 cycles, then advances by 4; fetch_cnt_o +1 only once. Repeat with stall_i=1 and gnt=1 → no advance, no count.
- Same cycle: trap_flag_i=1 (trap_addr_i=0000_0100) and branch_flag_i=1 (branch_addr_i=8000_0200) → pc_o=0000_0100, redirect_o pulses 1 cycle, misalign_o=0.
- branch_addr_i=8000_0206 with STEP=4 → pc_o=8000_0204, misalign_o=1 for 1 cycle. Branch while in HALT (fetch_en=0) → pc_o updated, if_req_o stays 0.
- fetch_cnt_o at 16'hFFFF plus one accept → 16'h0000. rst asserted mid-stall → all outputs return to reset values immediately, without waiting for a clock edge.
